// File: rtl/mem_seq_ctrl_if.sv
// Sequencer bus bundle: iRAM/data-RAM ports, ALU hookup and status.
interface mem_seq_ctrl_if #(
    parameter int unsigned DW   = 32,
    parameter int unsigned AW   = 10,
    parameter int unsigned OPW  = 2,
    parameter int unsigned CNTW = 16
);
    logic            run;
    logic [AW-1:0]   iaddr;
    logic [31:0]     irdata;
    logic [AW-1:0]   daddr;
    logic [DW-1:0]   drdata;
    logic [DW-1:0]   dwdata;
    logic            dwe;
    logic [OPW-1:0]  alu_op;
    logic [DW-1:0]   alu_a;
    logic [DW-1:0]   alu_b;
    logic [DW-1:0]   alu_y;
    logic [AW-1:0]   pc;
    logic            halted;
    logic            busy;
    logic [CNTW-1:0] retired;

    modport master (
        input  run, irdata, drdata, alu_y,
        output iaddr, daddr, dwdata, dwe, alu_op, alu_a, alu_b, pc, halted, busy, retired
    );

    modport slave (
        output run, irdata, drdata, alu_y,
        input  iaddr, daddr, dwdata, dwe, alu_op, alu_a, alu_b, pc, halted, busy, retired
    );
endinterface

// File: rtl/mem_seq_ctrl.sv
// Multi-cycle fetch / read-A / read-B / execute / write-back sequencer
// for the memory-to-memory CPU.
module mem_seq_ctrl #(
    parameter int unsigned DW   = 32,
    parameter int unsigned AW   = 10,
    parameter int unsigned OPW  = 2,
    parameter int unsigned CNTW = 16
) (
    input  logic           clk,
    input  logic           rst,
    mem_seq_ctrl_if.master bus
);
    localparam int unsigned IW     = 32;
    localparam int unsigned OP_LSB = 3 * AW;
    localparam int unsigned SA_LSB = 2 * AW;
    localparam int unsigned SB_LSB = AW;

    localparam logic [OPW-1:0] ALU_OP_AND  = OPW'(0);
    localparam logic [OPW-1:0] ALU_OP_OR   = OPW'(1);
    localparam logic [OPW-1:0] ALU_OP_XOR  = OPW'(2);
    localparam logic [OPW-1:0] CPU_OP_JUMP = OPW'(3);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_RDA, S_RDB, S_EXEC, S_WB, S_HALT
    } state_t;

    state_t          state;
    logic [AW-1:0]   pc;
    logic [IW-1:0]   ir;
    logic [DW-1:0]   opa;
    logic [DW-1:0]   opb;
    logic [AW-1:0]   daddr_q;
    logic [DW-1:0]   dwdata_q;
    logic            dwe;
    logic            halted;
    logic [CNTW-1:0] retired;

    logic [AW-1:0]   daddr_c;
    logic [DW-1:0]   dwdata_c;

    logic [OPW-1:0]  dec_op;
    logic [AW-1:0]   dec_tgt;
    logic [OPW-1:0]  ir_op;
    logic [AW-1:0]   ir_sa;
    logic [AW-1:0]   ir_sb;
    logic [AW-1:0]   ir_dst;

    assign dec_op  = bus.irdata[OP_LSB +: OPW];
    assign dec_tgt = bus.irdata[SA_LSB +: AW];
    assign ir_op   = ir[OP_LSB +: OPW];
    assign ir_sa   = ir[SA_LSB +: AW];
    assign ir_sb   = ir[SB_LSB +: AW];
    assign ir_dst  = ir[0 +: AW];

    // Data-RAM address/write data follow the state directly; the ALU result
    // is only valid once opb is latched, so write data cannot be pre-registered.
    always_comb begin
        daddr_c  = daddr_q;
        dwdata_c = dwdata_q;
        case (state)
            S_RDA:   daddr_c = ir_sa;
            S_RDB:   daddr_c = ir_sb;
            S_WB: begin
                daddr_c  = ir_dst;
                dwdata_c = bus.alu_y;
            end
            default: ;
        endcase
    end

    // Sequencer state, PC, instruction/operand latches and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_FETCH;
            pc       <= '0;
            ir       <= '0;
            opa      <= '0;
            opb      <= '0;
            daddr_q  <= '0;
            dwdata_q <= '0;
            dwe      <= 1'b0;
            halted   <= 1'b0;
            retired  <= '0;
        end else begin
            dwe      <= 1'b0;
            daddr_q  <= daddr_c;
            dwdata_q <= dwdata_c;
            case (state)
                S_FETCH: begin
                    if (bus.run) state <= S_DECODE;
                end
                S_DECODE: begin
                    ir <= bus.irdata;
                    case (dec_op)
                        CPU_OP_JUMP: begin
                            retired <= retired + CNTW'(1);
                            if (dec_tgt == pc) begin
                                halted <= 1'b1;
                                state  <= S_HALT;
                            end else begin
                                pc    <= dec_tgt;
                                state <= S_FETCH;
                            end
                        end
                        ALU_OP_AND, ALU_OP_OR, ALU_OP_XOR: begin
                            state <= S_RDA;
                        end
                        default: begin
                            pc      <= pc + AW'(1);
                            retired <= retired + CNTW'(1);
                            state   <= S_FETCH;
                        end
                    endcase
                end
                S_RDA:  state <= S_RDB;
                S_RDB: begin
                    opa   <= bus.drdata;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    opb   <= bus.drdata;
                    dwe   <= 1'b1;
                    state <= S_WB;
                end
                S_WB: begin
                    pc      <= pc + AW'(1);
                    retired <= retired + CNTW'(1);
                    state   <= S_FETCH;
                end
                S_HALT: ;
                default: state <= S_FETCH;
            endcase
        end
    end

    assign bus.iaddr   = pc;
    assign bus.pc      = pc;
    assign bus.daddr   = daddr_c;
    assign bus.dwdata  = dwdata_c;
    assign bus.dwe     = dwe;
    assign bus.alu_op  = ir_op;
    assign bus.alu_a   = opa;
    assign bus.alu_b   = opb;
    assign bus.halted  = halted;
    assign bus.retired = retired;
    assign bus.busy    = !((state == S_FETCH && !bus.run) || state == S_HALT);
endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Bench for mem_seq_ctrl: behavioural iRAM, data RAM and ALU around the DUT;
// expected data-RAM writes are queued and matched against each dwe pulse.
module tb_mem_seq_ctrl;
    localparam logic [1:0] OP_AND  = 2'd0;
    localparam logic [1:0] OP_OR   = 2'd1;
    localparam logic [1:0] OP_XOR  = 2'd2;
    localparam logic [1:0] OP_JUMP = 2'd3;

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_seq_ctrl_if #(.DW(32), .AW(10), .OPW(2), .CNTW(16)) bus ();

    mem_seq_ctrl #(.DW(32), .AW(10), .OPW(2), .CNTW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] iram [1024];
    logic [31:0] dram [1024];
    logic        ld_en;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;
    wr_t         exp_q [$];
    wr_t         mon_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read instruction RAM.
    always @(posedge clk) bus.irdata <= iram[bus.iaddr];

    // Synchronous data RAM with a bench-side load port.
    always @(posedge clk) begin
        if (ld_en) dram[ld_addr] <= ld_data;
        else if (bus.dwe) dram[bus.daddr] <= bus.dwdata;
        bus.drdata <= dram[bus.daddr];
    end

    // Reference ALU.
    always_comb begin
        case (bus.alu_op)
            OP_AND:  bus.alu_y = bus.alu_a & bus.alu_b;
            OP_OR:   bus.alu_y = bus.alu_a | bus.alu_b;
            OP_XOR:  bus.alu_y = bus.alu_a ^ bus.alu_b;
            default: bus.alu_y = 32'd0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ins(input logic [1:0] op, input logic [9:0] a,
                                        input logic [9:0] b, input logic [9:0] d);
        return {op, a, b, d};
    endfunction

    task automatic dload(input logic [9:0] a, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Scoreboard: every write pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.dwe) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 32'(bus.daddr), 32'h0000_ffff);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(bus.daddr), 32'(mon_e.addr));
                check("wr_data", bus.dwdata, mon_e.data);
            end
        end
    end

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b0;
        ld_en    = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;
        bus.run  = 1'b1;

        // Phase 1: OR, JUMP, AND, self-jump halt.
        iram[0] = ins(OP_OR, 10'd8, 10'd9, 10'd10);
        iram[1] = ins(OP_JUMP, 10'd4, 10'd0, 10'd0);
        iram[4] = ins(OP_AND, 10'd10, 10'd11, 10'd12);
        iram[5] = ins(OP_JUMP, 10'd5, 10'd0, 10'd0);
        dload(10'd8, 32'h0089_0005);
        dload(10'd9, 32'h0088_0006);
        dload(10'd11, 32'h00F9_0005);
        @(negedge clk);
        check("rst_pc", 32'(bus.pc), 32'd0);
        check("rst_iaddr", 32'(bus.iaddr), 32'd0);
        check("rst_dwe", 32'(bus.dwe), 32'd0);
        check("rst_halted", 32'(bus.halted), 32'd0);
        check("rst_retired", 32'(bus.retired), 32'd0);
        check("rst_daddr", 32'(bus.daddr), 32'd0);
        exp_q.push_back('{addr: 10'd10, data: 32'h0089_0007});
        exp_q.push_back('{addr: 10'd12, data: 32'h0089_0005});
        rst = 1'b1;
        step(5);
        check("or_dwe", 32'(bus.dwe), 32'd1);
        check("or_daddr", 32'(bus.daddr), 32'd10);
        check("or_dwdata", bus.dwdata, 32'h0089_0007);
        step(1);
        check("or_pc", 32'(bus.pc), 32'd1);
        check("or_retired", 32'(bus.retired), 32'd1);
        check("or_dwe_drop", 32'(bus.dwe), 32'd0);
        step(2);
        check("jmp_pc", 32'(bus.pc), 32'd4);
        check("jmp_iaddr", 32'(bus.iaddr), 32'd4);
        check("jmp_retired", 32'(bus.retired), 32'd2);
        step(6);
        check("and_pc", 32'(bus.pc), 32'd5);
        check("and_mem12", dram[12], 32'h0089_0005);
        step(2);
        check("halt_flag", 32'(bus.halted), 32'd1);
        check("halt_retired", 32'(bus.retired), 32'd4);
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("halt_busy", 32'(bus.busy), 32'd0);
            check("halt_pc", 32'(bus.pc), 32'd5);
            check("halt_dwe", 32'(bus.dwe), 32'd0);
        end

        // Phase 2: stall, in-place XOR, jump to 1023, wrap, run drop mid-op.
        rst = 1'b0;
        bus.run = 1'b0;
        iram[0]    = ins(OP_XOR, 10'd13, 10'd13, 10'd13);
        iram[1]    = ins(OP_JUMP, 10'd1023, 10'd0, 10'd0);
        iram[1023] = ins(OP_OR, 10'd8, 10'd9, 10'd14);
        dload(10'd13, 32'h0089_00FF);
        dload(10'd14, 32'h1234_5678);
        @(negedge clk);
        check("rst2_halted", 32'(bus.halted), 32'd0);
        exp_q.push_back('{addr: 10'd13, data: 32'h0000_0000});
        exp_q.push_back('{addr: 10'd14, data: 32'h0089_0007});
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("stall_pc", 32'(bus.pc), 32'd0);
            check("stall_busy", 32'(bus.busy), 32'd0);
        end
        bus.run = 1'b1;
        #1 check("run_busy", 32'(bus.busy), 32'd1);
        step(5);
        check("xor_dwe", 32'(bus.dwe), 32'd1);
        step(1);
        check("xor_mem13", dram[13], 32'h0000_0000);
        check("xor_pc", 32'(bus.pc), 32'd1);
        step(2);
        check("jmp1023_pc", 32'(bus.pc), 32'd1023);
        step(2);
        bus.run = 1'b0;
        step(3);
        check("wrap_dwe", 32'(bus.dwe), 32'd1);
        check("wrap_busy", 32'(bus.busy), 32'd1);
        step(1);
        check("wrap_pc", 32'(bus.pc), 32'd0);
        check("wrap_retired", 32'(bus.retired), 32'd3);
        check("idle_busy", 32'(bus.busy), 32'd0);
        step(4);
        check("idle_pc", 32'(bus.pc), 32'd0);
        check("wrap_mem14", dram[14], 32'h0089_0007);

        // Phase 3: reset asserted in the middle of WB.
        rst = 1'b0;
        bus.run = 1'b1;
        iram[0] = ins(OP_JUMP, 10'd2, 10'd0, 10'd0);
        iram[2] = ins(OP_OR, 10'd8, 10'd9, 10'd10);
        dload(10'd10, 32'hDEAD_BEEF);
        @(negedge clk);
        exp_q.push_back('{addr: 10'd10, data: 32'h0089_0007});
        rst = 1'b1;
        step(7);
        check("wb3_dwe", 32'(bus.dwe), 32'd1);
        check("wb3_retired", 32'(bus.retired), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rstwb_dwe", 32'(bus.dwe), 32'd0);
        check("rstwb_pc", 32'(bus.pc), 32'd0);
        check("rstwb_retired", 32'(bus.retired), 32'd0);
        check("rstwb_iaddr", 32'(bus.iaddr), 32'd0);
        step(1);
        check("rstwb_mem10", dram[10], 32'hDEAD_BEEF);
        check("rstwb_busy", 32'(bus.busy), 32'd1);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
